// File: rtl/pcie_regfile_array.sv
// Register file with byte-lane writes, read-only status and W1C registers, and a tagged
// read-response FIFO. Registers sit at byte address i*8+4.
module pcie_regfile_array #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned RSP_DEPTH = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
    input  logic                     clk_in,
    input  logic                     rstn,
    input  logic                     wr_valid_in,
    output logic                     wr_ready_out,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_in,
    input  logic [31:0]              wr_data_in,
    input  logic [3:0]               wr_be_in,
    input  logic                     rd_valid_in,
    output logic                     rd_ready_out,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_in,
    input  logic [TAG_WIDTH-1:0]     rd_tag_in,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [31:0]              rsp_data_out,
    output logic [TAG_WIDTH-1:0]     rsp_tag_out,
    output logic [NUM_REGS*32-1:0]   regs_out,
    input  logic [NUM_REGS*32-1:0]   status_in,
    output logic [NUM_REGS-1:0]      wr_strobe_out
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = RSP_DEPTH[PTR_W:0];

    logic                         ready_q;
    logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]          strobe_q, strobe_d;
    logic [NUM_REGS-1:0][31:0]    status_w;
    logic [31:0]                  fifo_data_q [RSP_DEPTH];
    logic [TAG_WIDTH-1:0]         fifo_tag_q [RSP_DEPTH];
    logic [PTR_W-1:0]             wptr_q, rptr_q;
    logic [PTR_W:0]               count_q;

    logic                         wr_acc, rd_acc, pop, wr_hit, rd_hit;
    logic [IDX_W-1:0]             wr_idx, rd_idx;
    logic [NUM_REGS-1:0]          wr_dec;
    logic [31:0]                  be_mask, rd_data;
    logic                         unused_addr_lsbs;

    assign unused_addr_lsbs = ^{wr_addr_in[1:0], rd_addr_in[1:0]};

    assign status_w = status_in;
    assign regs_out = regs_q;
    assign wr_strobe_out = strobe_q;

    // Readies are gated by rstn so they fall in the same cycle reset is asserted.
    assign wr_ready_out  = ready_q & rstn;
    assign rd_ready_out  = ready_q & rstn & (count_q < DEPTH_CNT);
    assign rsp_valid_out = (count_q != '0) & rstn;

    assign wr_acc = wr_valid_in & wr_ready_out;
    assign rd_acc = rd_valid_in & rd_ready_out;
    assign pop    = rsp_valid_out & rsp_ready_in;

    assign wr_idx = wr_addr_in[2+IDX_W:3];
    assign rd_idx = rd_addr_in[2+IDX_W:3];
    assign wr_hit = wr_addr_in[2] & ((wr_addr_in >> (3 + IDX_W)) == '0);
    assign rd_hit = rd_addr_in[2] & ((rd_addr_in >> (3 + IDX_W)) == '0);

    assign be_mask = {{8{wr_be_in[3]}}, {8{wr_be_in[2]}}, {8{wr_be_in[1]}}, {8{wr_be_in[0]}}};

    always_comb begin
        wr_dec = '0;
        if (wr_acc && wr_hit) begin
            wr_dec[wr_idx] = 1'b1;
        end
    end

    // Read data comes from the pre-edge register state, so a same-cycle write is not seen.
    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            rd_data = RO_MASK[rd_idx] ? status_w[rd_idx] : regs_q[rd_idx];
        end
    end

    always_comb begin
        regs_d   = regs_q;
        strobe_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                regs_d[i] = status_w[i];
            end else if (W1C_MASK[i]) begin
                // Status set is OR-ed in after the clear so set wins.
                regs_d[i] = (regs_q[i] & ~(wr_dec[i] ? (wr_data_in & be_mask) : 32'h0))
                            | status_w[i];
            end else if (wr_dec[i]) begin
                regs_d[i] = (regs_q[i] & ~be_mask) | (wr_data_in & be_mask);
            end
            strobe_d[i] = wr_dec[i] & ~RO_MASK[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            ready_q  <= 1'b0;
            regs_q   <= '0;
            strobe_q <= '0;
        end else begin
            ready_q  <= 1'b1;
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (rd_acc) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (rd_acc && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!rd_acc && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rd_acc) begin
            fifo_data_q[wptr_q] <= rd_data;
            fifo_tag_q[wptr_q]  <= rd_tag_in;
        end
    end

    assign rsp_data_out = fifo_data_q[rptr_q];
    assign rsp_tag_out  = fifo_tag_q[rptr_q];

endmodule

// File: tb/tb_pcie_regfile_array.sv
// Bench for pcie_regfile_array: directed scenarios plus randomized traffic checked against a
// transaction-level model (register array + response queue).
module tb_pcie_regfile_array;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned RSP_DEPTH = 4;
    localparam logic [NUM_REGS-1:0] RO = 8'h01;
    localparam logic [NUM_REGS-1:0] W1C = 8'h08;

    logic clk_in = 1'b0;
    logic rstn = 1'b0;
    logic wr_valid_in = 1'b0;
    logic wr_ready_out;
    logic [15:0] wr_addr_in = '0;
    logic [31:0] wr_data_in = '0;
    logic [3:0] wr_be_in = '0;
    logic rd_valid_in = 1'b0;
    logic rd_ready_out;
    logic [15:0] rd_addr_in = '0;
    logic [7:0] rd_tag_in = '0;
    logic rsp_valid_out;
    logic rsp_ready_in = 1'b0;
    logic [31:0] rsp_data_out;
    logic [7:0] rsp_tag_out;
    logic [NUM_REGS*32-1:0] regs_out;
    logic [NUM_REGS*32-1:0] status_in = '0;
    logic [NUM_REGS-1:0] wr_strobe_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mregs [NUM_REGS];
    logic [NUM_REGS-1:0] m_strobe = '0;
    bit          m_rdy = 1'b0;

    pcie_regfile_array #(
        .NUM_REGS(NUM_REGS),
        .ADDR_WIDTH(16),
        .TAG_WIDTH(8),
        .RSP_DEPTH(RSP_DEPTH),
        .RO_MASK(RO),
        .W1C_MASK(W1C)
    ) dut (
        .clk_in(clk_in),
        .rstn(rstn),
        .wr_valid_in(wr_valid_in),
        .wr_ready_out(wr_ready_out),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .wr_be_in(wr_be_in),
        .rd_valid_in(rd_valid_in),
        .rd_ready_out(rd_ready_out),
        .rd_addr_in(rd_addr_in),
        .rd_tag_in(rd_tag_in),
        .rsp_valid_out(rsp_valid_out),
        .rsp_ready_in(rsp_ready_in),
        .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out),
        .regs_out(regs_out),
        .status_in(status_in),
        .wr_strobe_out(wr_strobe_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit in_range(logic [15:0] a);
        return a[2] && (int'(a) < int'(NUM_REGS * 8));
    endfunction

    function automatic logic [NUM_REGS*32-1:0] model_packed();
        logic [NUM_REGS*32-1:0] p;
        for (int i = 0; i < int'(NUM_REGS); i++) p[i*32 +: 32] = mregs[i];
        return p;
    endfunction

    // Advance one clock; update the model from the inputs seen at the edge; return at negedge.
    task automatic tick();
        rsp_t r;
        bit pop, push, wacc, hit;
        int widx, ridx;
        logic [31:0] m, st;
        @(posedge clk_in);
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) mregs[i] = '0;
            q.delete();
            m_strobe = '0;
            m_rdy = 1'b0;
        end else begin
            pop  = (q.size() > 0) && rsp_ready_in;
            push = m_rdy && rd_valid_in && (q.size() < int'(RSP_DEPTH));
            wacc = m_rdy && wr_valid_in;
            ridx = int'(rd_addr_in) / 8;
            widx = int'(wr_addr_in) / 8;
            r.tag = rd_tag_in;
            r.data = '0;
            if (in_range(rd_addr_in))
                r.data = RO[ridx] ? status_in[ridx*32 +: 32] : mregs[ridx];
            if (pop) void'(q.pop_front());
            if (push) q.push_back(r);
            for (int b = 0; b < 4; b++) m[b*8 +: 8] = wr_be_in[b] ? 8'hFF : 8'h00;
            m_strobe = '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                hit = wacc && in_range(wr_addr_in) && (widx == i);
                st = status_in[i*32 +: 32];
                if (RO[i]) mregs[i] = st;
                else if (W1C[i]) mregs[i] = (mregs[i] & ~(hit ? (wr_data_in & m) : 32'h0)) | st;
                else if (hit) mregs[i] = (mregs[i] & ~m) | (wr_data_in & m);
                if (hit && !RO[i]) m_strobe[i] = 1'b1;
            end
            m_rdy = 1'b1;
        end
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        wr_valid_in = 0;
        rd_valid_in = 0;
        rstn = 0;
        tick();
        tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        rstn = 0;
        #1;
        checks++;
        if (wr_ready_out !== 1'b0 || rd_ready_out !== 1'b0 || rsp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got wr_rdy=%b rd_rdy=%b rsp_v=%b want 0 0 0",
                     wr_ready_out, rd_ready_out, rsp_valid_out);
        end
        tick();
        checks++;
        if (regs_out !== '0 || wr_strobe_out !== '0) begin
            failures++;
            $display("FAIL reset_regs: got regs=%h strobe=%b want 0", regs_out, wr_strobe_out);
        end
        rstn = 1;
        #1;
        checks++;
        if (wr_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_rdy: got %b want 0 before first edge", wr_ready_out);
        end
        tick();
        checks++;
        if (wr_ready_out !== 1'b1 || rd_ready_out !== 1'b1 || rsp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_after: got wr_rdy=%b rd_rdy=%b rsp_v=%b want 1 1 0",
                     wr_ready_out, rd_ready_out, rsp_valid_out);
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] vals [6] = '{32'h34D9E13F, 32'h863FFC01, 32'h4954F539,
                                  32'h28B3C29E, 32'h1B6B3B92, 32'h92033EB1};
        // Register 3 (0x1C) is W1C here, so writing ones clears it and it reads back zero.
        logic [31:0] exp [6] = '{32'h34D9E13F, 32'h00000000, 32'h4954F539,
                                 32'h28B3C29E, 32'h1B6B3B92, 32'h92033EB1};
        int n = 0;
        for (int k = 0; k < 6; k++) begin
            wr_addr_in = 16'h14 + 16'(k * 8);
            wr_data_in = vals[k];
            wr_be_in = 4'hF;
            wr_valid_in = 1;
            tick();
            wr_valid_in = 0;
            checks++;
            if (wr_strobe_out !== 8'(1 << (k + 2))) begin
                failures++;
                $display("FAIL wb_strobe[%0d]: got %b want %b", k, wr_strobe_out, 8'(1 << (k + 2)));
            end
        end
        tick();
        checks++;
        if (wr_strobe_out !== '0) begin
            failures++;
            $display("FAIL wb_strobe_idle: got %b want 0", wr_strobe_out);
        end
        rsp_ready_in = 1;
        for (int cyc = 0; cyc < 20 && n < 6; cyc++) begin
            rd_valid_in = (cyc < 6);
            rd_addr_in = 16'h14 + 16'(cyc * 8);
            rd_tag_in = 8'(cyc);
            tick();
            if (rsp_valid_out) begin
                checks++;
                if (rsp_data_out !== exp[n] || rsp_tag_out !== 8'(n)) begin
                    failures++;
                    $display("FAIL wb_read[%0d]: got %h/%0d want %h/%0d",
                             n, rsp_data_out, rsp_tag_out, exp[n], n);
                end
                n++;
            end
        end
        rd_valid_in = 0;
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL wb_read_timeout: got %0d responses want 6", n);
        end
        tick();
    endtask

    task automatic test_byte_enable_and_range();
        apply_reset();
        rsp_ready_in = 1;
        wr_addr_in = 16'h0C;
        wr_data_in = 32'hFFFFFFFF;
        wr_be_in = 4'b0101;
        wr_valid_in = 1;
        tick();
        wr_valid_in = 0;
        checks++;
        if (regs_out[63:32] !== 32'h00FF00FF || wr_strobe_out !== 8'h02) begin
            failures++;
            $display("FAIL be_write: got %h strobe %b want 00ff00ff strobe 00000010",
                     regs_out[63:32], wr_strobe_out);
        end
        rd_addr_in = 16'h0C;
        rd_tag_in = 8'h21;
        rd_valid_in = 1;
        tick();
        rd_valid_in = 0;
        checks++;
        if (rsp_valid_out !== 1'b1 || rsp_data_out !== 32'h00FF00FF || rsp_tag_out !== 8'h21) begin
            failures++;
            $display("FAIL be_read: got v=%b %h/%h want 1 00ff00ff/21",
                     rsp_valid_out, rsp_data_out, rsp_tag_out);
        end
        wr_addr_in = 16'h10;
        wr_data_in = 32'hDEADBEEF;
        wr_be_in = 4'hF;
        wr_valid_in = 1;
        tick();
        wr_valid_in = 0;
        checks++;
        if (wr_strobe_out !== '0 || regs_out[95:64] !== 32'h0 || regs_out !== model_packed()) begin
            failures++;
            $display("FAIL oor_write: got strobe %b regs %h want no change", wr_strobe_out, regs_out);
        end
        rd_addr_in = 16'h10;
        rd_tag_in = 8'h22;
        rd_valid_in = 1;
        tick();
        rd_valid_in = 0;
        checks++;
        if (rsp_valid_out !== 1'b1 || rsp_data_out !== 32'h0 || rsp_tag_out !== 8'h22) begin
            failures++;
            $display("FAIL oor_read: got v=%b %h/%h want 1 00000000/22",
                     rsp_valid_out, rsp_data_out, rsp_tag_out);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n = 0;
        bit sent = 0;
        bit rdy_now;
        rsp_ready_in = 0;
        rd_addr_in = 16'h0C;
        rd_valid_in = 1;
        for (int cyc = 0; cyc < 20 && acc < int'(RSP_DEPTH); cyc++) begin
            rd_tag_in = 8'(acc);
            rdy_now = rd_ready_out;
            tick();
            if (rdy_now) acc++;
        end
        rd_tag_in = 8'(RSP_DEPTH);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_ready_out !== 1'b0 || rsp_valid_out !== 1'b1 || rsp_tag_out !== 8'h00) begin
                failures++;
                $display("FAIL bp_full[%0d]: got rd_rdy=%b v=%b tag=%h want 0 1 00",
                         k, rd_ready_out, rsp_valid_out, rsp_tag_out);
            end
            tick();
        end
        rsp_ready_in = 1;
        for (int cyc = 0; cyc < 30 && n < int'(RSP_DEPTH) + 1; cyc++) begin
            if (rsp_valid_out) begin
                checks++;
                if (rsp_tag_out !== 8'(n) || rsp_data_out !== 32'h00FF00FF) begin
                    failures++;
                    $display("FAIL bp_drain[%0d]: got %h/%0d want 00ff00ff/%0d",
                             n, rsp_data_out, rsp_tag_out, n);
                end
                n++;
            end
            if (rd_valid_in && rd_ready_out) sent = 1;
            tick();
            if (sent) rd_valid_in = 0;
        end
        rd_valid_in = 0;
        checks++;
        if (n != int'(RSP_DEPTH) + 1) begin
            failures++;
            $display("FAIL bp_timeout: got %0d responses want %0d", n, RSP_DEPTH + 1);
        end
        checks++;
        if (rd_ready_out !== 1'b1 || rsp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got rd_rdy=%b v=%b want 1 0", rd_ready_out, rsp_valid_out);
        end
    endtask

    task automatic test_w1c();
        apply_reset();
        rsp_ready_in = 1;
        status_in[96] = 1'b1;
        tick();
        status_in[96] = 1'b0;
        checks++;
        if (regs_out[127:96] !== 32'h1) begin
            failures++;
            $display("FAIL w1c_set: got %h want 00000001", regs_out[127:96]);
        end
        rd_addr_in = 16'h1C;
        rd_tag_in = 8'h30;
        rd_valid_in = 1;
        tick();
        rd_valid_in = 0;
        checks++;
        if (rsp_valid_out !== 1'b1 || rsp_data_out !== 32'h1) begin
            failures++;
            $display("FAIL w1c_read: got v=%b %h want 1 00000001", rsp_valid_out, rsp_data_out);
        end
        status_in[96] = 1'b1;
        wr_addr_in = 16'h1C;
        wr_data_in = 32'h1;
        wr_be_in = 4'hF;
        wr_valid_in = 1;
        tick();
        checks++;
        if (regs_out[127:96] !== 32'h1) begin
            failures++;
            $display("FAIL w1c_set_wins: got %h want 00000001", regs_out[127:96]);
        end
        status_in[96] = 1'b0;
        tick();
        wr_valid_in = 0;
        checks++;
        if (regs_out[127:96] !== 32'h0) begin
            failures++;
            $display("FAIL w1c_clear: got %h want 00000000", regs_out[127:96]);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        rsp_ready_in = 0;
        wr_addr_in = 16'h2C;
        wr_data_in = 32'hA5A5_1234;
        wr_be_in = 4'hF;
        wr_valid_in = 1;
        tick();
        wr_valid_in = 0;
        rd_addr_in = 16'h2C;
        rd_valid_in = 1;
        for (int k = 0; k < 3; k++) begin
            rd_tag_in = 8'(8'h40 + k);
            tick();
        end
        rd_valid_in = 0;
        checks++;
        if (rsp_valid_out !== 1'b1 || regs_out[191:160] !== 32'hA5A51234) begin
            failures++;
            $display("FAIL mid_setup: got v=%b reg5=%h want 1 a5a51234", rsp_valid_out,
                     regs_out[191:160]);
        end
        rstn = 0;
        #1;
        checks++;
        if (rsp_valid_out !== 1'b0 || wr_ready_out !== 1'b0 || rd_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got v=%b wr_rdy=%b rd_rdy=%b want 0 0 0",
                     rsp_valid_out, wr_ready_out, rd_ready_out);
        end
        tick();
        checks++;
        if (regs_out !== '0 || wr_strobe_out !== '0) begin
            failures++;
            $display("FAIL mid_regs: got %h strobe %b want 0", regs_out, wr_strobe_out);
        end
        rstn = 1;
        tick();
        rsp_ready_in = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rsp_valid_out !== 1'b0 || rd_ready_out !== 1'b1) begin
                failures++;
                $display("FAIL mid_stale[%0d]: got v=%b rd_rdy=%b want 0 1",
                         k, rsp_valid_out, rd_ready_out);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int idx;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (wr_ready_out !== 1'b1 || rd_ready_out !== (q.size() < int'(RSP_DEPTH)) ||
                rsp_valid_out !== (q.size() != 0)) begin
                failures++;
                $display("FAIL rnd_hs[%0d]: got wr=%b rd=%b v=%b want 1 %b %b", cyc,
                         wr_ready_out, rd_ready_out, rsp_valid_out,
                         q.size() < int'(RSP_DEPTH), q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (rsp_data_out !== q[0].data || rsp_tag_out !== q[0].tag) begin
                    failures++;
                    $display("FAIL rnd_rsp[%0d]: got %h/%h want %h/%h", cyc,
                             rsp_data_out, rsp_tag_out, q[0].data, q[0].tag);
                end
            end
            checks++;
            if (regs_out !== model_packed() || wr_strobe_out !== m_strobe) begin
                failures++;
                $display("FAIL rnd_regs[%0d]: got %h/%b want %h/%b", cyc,
                         regs_out, wr_strobe_out, model_packed(), m_strobe);
            end
            idx = int'($urandom_range(0, NUM_REGS - 1));
            wr_valid_in = ($urandom_range(0, 1) == 1);
            wr_addr_in = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                         : 16'(idx * 8 + 4 + int'($urandom_range(0, 3)));
            wr_data_in = $urandom;
            wr_be_in = 4'($urandom);
            idx = int'($urandom_range(0, NUM_REGS - 1));
            rd_valid_in = ($urandom_range(0, 1) == 1);
            rd_addr_in = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                         : 16'(idx * 8 + 4 + int'($urandom_range(0, 3)));
            rd_tag_in = 8'($urandom);
            rsp_ready_in = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < int'(NUM_REGS); i++) status_in[i*32 +: 32] = $urandom & $urandom;
            tick();
        end
        wr_valid_in = 0;
        rd_valid_in = 0;
        status_in = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(NUM_REGS); i++) mregs[i] = '0;
        test_reset();
        test_write_readback();
        test_byte_enable_and_range();
        test_backpressure();
        test_w1c();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
